// File: rtl/qpel_interp_pipe.sv
// qpel_interp_pipe: separable 8-tap quarter-pel interpolator. Each accepted reference row is
// filtered horizontally, shifted into an 8-row buffer, and once the buffer holds a full
// vertical window one clipped output row is registered per accepted row.
module qpel_interp_pipe #(
    parameter int BLK   = 8,
    parameter int PIX_W = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [1:0]               frac_x,
    input  logic [1:0]               frac_y,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [(BLK+7)*PIX_W-1:0] in_row,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [BLK*PIX_W-1:0]     out_row,
    output logic                     busy,
    output logic                     done
);

    localparam int NTAP = 8;
    localparam int RinW = $clog2(BLK + 7);
    localparam logic [RinW-1:0] RinLast = RinW'(BLK + 6);
    localparam logic [RinW-1:0] RinOut  = RinW'(7);

    localparam logic signed [7:0] TapA [NTAP] =
        '{-8'sd1, 8'sd4, -8'sd10, 8'sd58, 8'sd17, -8'sd5, 8'sd1, 8'sd0};
    localparam logic signed [7:0] TapB [NTAP] =
        '{-8'sd1, 8'sd4, -8'sd11, 8'sd40, 8'sd40, -8'sd11, 8'sd4, -8'sd1};
    localparam logic signed [7:0] TapC [NTAP] =
        '{8'sd0, 8'sd1, -8'sd5, 8'sd17, 8'sd58, -8'sd10, 8'sd4, -8'sd1};

    typedef enum logic [1:0] {StIdle, StLoad, StFlush} state_e;

    state_e             state_q, state_d;
    logic [RinW-1:0]    rin_q;
    logic [1:0]         frac_x_q, frac_y_q;
    logic signed [15:0] rowbuf_q [NTAP][BLK];
    logic signed [15:0] win [NTAP][BLK];
    logic signed [15:0] h_new [BLK];
    logic [BLK*PIX_W-1:0] out_row_d, out_row_q;
    logic               out_valid_q, done_q;
    logic               in_fire, out_fire, produce;

    function automatic logic signed [7:0] tap_coef(input logic [1:0] phase, input logic [2:0] k);
        case (phase)
            2'd1:    return TapA[k];
            2'd2:    return TapB[k];
            2'd3:    return TapC[k];
            default: return 8'sd0;
        endcase
    endfunction

    assign in_fire  = in_valid && in_ready;
    assign out_fire = out_valid_q && out_ready;
    assign produce  = in_fire && (rin_q >= RinOut);

    // Horizontal 8-tap filter of the incoming row; the result always fits in 16 bits.
    always_comb begin
        logic signed [15:0] acc;
        acc = '0;
        for (int i = 0; i < BLK; i++) begin
            acc = '0;
            if (frac_x_q == 2'd0) begin
                acc = $signed(16'(in_row[(i+3)*PIX_W +: PIX_W])) <<< 6;
            end else begin
                for (int k = 0; k < NTAP; k++) begin
                    acc = acc + 16'(tap_coef(frac_x_q, 3'(k)))
                              * $signed(16'(in_row[(i+k)*PIX_W +: PIX_W]));
                end
            end
            h_new[i] = acc;
        end
    end

    // Window as it will look after this row shifts in, vertical filter, round and clip.
    always_comb begin
        logic signed [23:0] acc;
        logic signed [23:0] rnd;
        acc       = '0;
        rnd       = '0;
        out_row_d = '0;
        for (int k = 0; k < NTAP - 1; k++) begin
            for (int i = 0; i < BLK; i++) win[k][i] = rowbuf_q[k+1][i];
        end
        for (int i = 0; i < BLK; i++) win[NTAP-1][i] = h_new[i];
        for (int i = 0; i < BLK; i++) begin
            acc = '0;
            if (frac_y_q == 2'd0) begin
                acc = 24'(win[3][i]) <<< 6;
            end else begin
                for (int k = 0; k < NTAP; k++) begin
                    acc = acc + 24'(tap_coef(frac_y_q, 3'(k))) * 24'(win[k][i]);
                end
            end
            rnd = (acc + 24'sd2048) >>> 12;
            if (rnd < 24'sd0) begin
                out_row_d[i*PIX_W +: PIX_W] = '0;
            end else if (rnd > 24'sd255) begin
                out_row_d[i*PIX_W +: PIX_W] = '1;
            end else begin
                out_row_d[i*PIX_W +: PIX_W] = PIX_W'(rnd);
            end
        end
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) state_q <= StIdle;
        else     state_q <= state_d;
    end

    // FSM next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (start) state_d = StLoad;
            StLoad:  if (in_fire && rin_q == RinLast) state_d = StFlush;
            StFlush: if (out_fire) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // FSM outputs; input stalls only while an unaccepted output row is pending
    always_comb begin
        busy     = (state_q != StIdle);
        in_ready = (state_q == StLoad) && (!out_valid_q || out_ready);
    end

    // Datapath registers: phase latch, row counter, row buffer, output row and done pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            rin_q       <= '0;
            frac_x_q    <= '0;
            frac_y_q    <= '0;
            out_valid_q <= 1'b0;
            out_row_q   <= '0;
            done_q      <= 1'b0;
            for (int k = 0; k < NTAP; k++) begin
                for (int i = 0; i < BLK; i++) rowbuf_q[k][i] <= '0;
            end
        end else begin
            if (state_q == StIdle && start) begin
                frac_x_q <= frac_x;
                frac_y_q <= frac_y;
                rin_q    <= '0;
            end
            if (in_fire) begin
                for (int k = 0; k < NTAP; k++) begin
                    for (int i = 0; i < BLK; i++) rowbuf_q[k][i] <= win[k][i];
                end
                rin_q <= (rin_q == RinLast) ? '0 : rin_q + 1'b1;
            end
            // A producing row wins over a same-cycle drain so out_valid stays high.
            if (produce) begin
                out_row_q   <= out_row_d;
                out_valid_q <= 1'b1;
            end else if (out_fire) begin
                out_valid_q <= 1'b0;
            end
            done_q <= (state_q == StFlush) && out_fire;
        end
    end

    assign out_valid = out_valid_q;
    assign out_row   = out_row_q;
    assign done      = done_q;

endmodule
